dense_layer_engine: RTL and testbench



---
 rtl/dense_layer_engine.sv | 160 ++++++++++++++++
 tb/tb_dense_layer_engine.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dense_layer_engine.sv
// Dense layer: binary input x signed ROM weights, plus per-neuron bias, then identity/ReLU/leaky activation.
// Latency: done pulses in the cycle after edge load+CHUNKS+3; weight ROM must have exactly 1-cycle read latency.
// Backpressure: none; load is ignored while busy (never queued) and the engine never stalls.
module dense_layer_engine #(
    parameter int IN_SIZE    = 256,
    parameter int NEURONS    = 20,
    parameter int LANES      = 8,
    parameter int W_SIZE     = 8,
    parameter int OUT_SIZE   = 32,
    parameter int LEAK_SHIFT = 3,
    localparam int CHUNKS    = IN_SIZE / LANES,
    localparam int ADDR_W    = $clog2(CHUNKS + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load,
    input  logic [IN_SIZE-1:0]            layer_input,
    input  logic [1:0]                    act_mode,
    output logic                          busy,
    output logic                          done,
    output logic                          sat,
    output logic                          w_rd,
    output logic [ADDR_W-1:0]             w_addr,
    input  logic [NEURONS*LANES*W_SIZE-1:0] w_data,
    output logic [NEURONS*OUT_SIZE-1:0]   layer_output
);

    // Wide enough to hold acc plus a full chunk of weights without wrapping.
    localparam int EXT_W = OUT_SIZE + W_SIZE + $clog2(LANES) + 2;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CHUNKS);
    localparam logic signed [EXT_W-1:0] MAX_EXT = {{(EXT_W-OUT_SIZE+1){1'b0}}, {(OUT_SIZE-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] MIN_EXT = {{(EXT_W-OUT_SIZE+1){1'b1}}, {(OUT_SIZE-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, BIAS, ACT} state_t;

    state_t                      state, state_nxt;
    logic [IN_SIZE-1:0]          in_sh;
    logic [1:0]                  mode;
    logic                        rd_q;
    logic signed [OUT_SIZE-1:0]  acc     [NEURONS];
    logic signed [OUT_SIZE-1:0]  acc_nxt [NEURONS];
    logic signed [EXT_W-1:0]     addend  [NEURONS];
    logic signed [EXT_W-1:0]     sum     [NEURONS];
    logic [NEURONS-1:0]          ovf;

    function automatic logic signed [EXT_W-1:0] lane_w(input int n, input int l);
        logic [W_SIZE-1:0] w;
        w = w_data[(n*LANES+l)*W_SIZE +: W_SIZE];
        return {{(EXT_W-W_SIZE){w[W_SIZE-1]}}, w};
    endfunction

    function automatic logic [OUT_SIZE-1:0] activate(input logic signed [OUT_SIZE-1:0] a,
                                                     input logic [1:0] m);
        if (m == 2'b00 || !a[OUT_SIZE-1]) return a;
        if (m == 2'b01) return '0;
        return a >>> LEAK_SHIFT;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = RUN;
            RUN:     if (w_addr == LAST_ADDR) state_nxt = BIAS;
            BIAS:    state_nxt = ACT;
            ACT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The top LANES bits of in_sh always belong to the chunk whose weights are on w_data.
    always_comb begin
        ovf = '0;
        for (int n = 0; n < NEURONS; n++) begin
            addend[n]  = '0;
            sum[n]     = '0;
            acc_nxt[n] = acc[n];
            for (int l = 0; l < LANES; l++) begin
                if (state == BIAS) begin
                    if (l == 0) addend[n] = addend[n] + lane_w(n, 0);
                end else if (in_sh[IN_SIZE-1-l]) begin
                    addend[n] = addend[n] + lane_w(n, l);
                end
            end
            sum[n] = {{(EXT_W-OUT_SIZE){acc[n][OUT_SIZE-1]}}, acc[n]} + addend[n];
            if (sum[n] > MAX_EXT) begin
                acc_nxt[n] = MAX_EXT[OUT_SIZE-1:0];
                ovf[n]     = 1'b1;
            end else if (sum[n] < MIN_EXT) begin
                acc_nxt[n] = MIN_EXT[OUT_SIZE-1:0];
                ovf[n]     = 1'b1;
            end else begin
                acc_nxt[n] = sum[n][OUT_SIZE-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            sat          <= 1'b0;
            w_rd         <= 1'b0;
            w_addr       <= '0;
            rd_q         <= 1'b0;
            mode         <= 2'b00;
            in_sh        <= '0;
            layer_output <= '0;
            for (int n = 0; n < NEURONS; n++) acc[n] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        in_sh  <= layer_input;
                        mode   <= act_mode;
                        sat    <= 1'b0;
                        w_rd   <= 1'b1;
                        w_addr <= '0;
                        busy   <= 1'b1;
                        rd_q   <= 1'b0;
                        for (int n = 0; n < NEURONS; n++) acc[n] <= '0;
                    end
                end
                RUN: begin
                    // The first RUN cycle has no ROM data yet.
                    rd_q <= 1'b1;
                    if (rd_q) begin
                        for (int n = 0; n < NEURONS; n++) acc[n] <= acc_nxt[n];
                        sat   <= sat | (|ovf);
                        in_sh <= in_sh << LANES;
                    end
                    if (w_addr == LAST_ADDR) begin
                        w_rd   <= 1'b0;
                        w_addr <= '0;
                    end else begin
                        w_addr <= w_addr + ADDR_W'(1);
                    end
                end
                BIAS: begin
                    rd_q <= 1'b0;
                    for (int n = 0; n < NEURONS; n++) acc[n] <= acc_nxt[n];
                    sat <= sat | (|ovf);
                end
                ACT: begin
                    for (int n = 0; n < NEURONS; n++)
                        layer_output[n*OUT_SIZE +: OUT_SIZE] <= activate(acc[n], mode);
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dense_layer_engine.sv
// Directed bench for dense_layer_engine: default, OUT_SIZE=8 and LANES=1 instances share clock/reset,
// each with its own 1-cycle-latency weight ROM model.
module tb_dense_layer_engine;
    localparam int NEU = 20;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [255:0] vec;
    logic [1:0]   mode;
    logic         load_a, load_b, load_c;

    logic busy_a, done_a, sat_a, rd_a;
    logic busy_b, done_b, sat_b, rd_b;
    logic busy_c, done_c, sat_c, rd_c;
    logic [5:0] addr_a, addr_b;
    logic [8:0] addr_c;
    logic [NEU*8*8-1:0] wd_a = '0;
    logic [NEU*8*8-1:0] wd_b = '0;
    logic [NEU*8-1:0]   wd_c = '0;
    logic [NEU*32-1:0]  out_a;
    logic [NEU*8-1:0]   out_b;
    logic [NEU*32-1:0]  out_c;

    // ROM contents are driven by these knobs
    int w_val      = 0;
    int bias_const = 0;
    bit bias_ramp  = 0;
    bit special    = 0;

    int n_cmp = 0;
    int n_err = 0;

    dense_layer_engine dut_a (
        .clk(clk), .reset(reset), .load(load_a), .layer_input(vec), .act_mode(mode),
        .busy(busy_a), .done(done_a), .sat(sat_a), .w_rd(rd_a), .w_addr(addr_a),
        .w_data(wd_a), .layer_output(out_a));

    dense_layer_engine #(.OUT_SIZE(8)) dut_b (
        .clk(clk), .reset(reset), .load(load_b), .layer_input(vec), .act_mode(mode),
        .busy(busy_b), .done(done_b), .sat(sat_b), .w_rd(rd_b), .w_addr(addr_b),
        .w_data(wd_b), .layer_output(out_b));

    dense_layer_engine #(.LANES(1)) dut_c (
        .clk(clk), .reset(reset), .load(load_c), .layer_input(vec), .act_mode(mode),
        .busy(busy_c), .done(done_c), .sat(sat_c), .w_rd(rd_c), .w_addr(addr_c),
        .w_data(wd_c), .layer_output(out_c));

    // Non-zero junk in bias-row lanes 1..7 must be ignored by the engine.
    function automatic int w_of(input int addr, input int chunks, input int lane, input int n);
        if (addr == chunks) return (lane != 0) ? 55 : (bias_ramp ? n - 10 : bias_const);
        if (special && addr == 0 && lane == 0) return 7;
        return w_val;
    endfunction

    always @(posedge clk) begin
        if (rd_a)
            for (int n = 0; n < NEU; n++)
                for (int l = 0; l < 8; l++)
                    wd_a[(n*8+l)*8 +: 8] <= 8'(w_of(int'(addr_a), 32, l, n));
        if (rd_b)
            for (int n = 0; n < NEU; n++)
                for (int l = 0; l < 8; l++)
                    wd_b[(n*8+l)*8 +: 8] <= 8'(w_of(int'(addr_b), 32, l, n));
        if (rd_c)
            for (int n = 0; n < NEU; n++)
                wd_c[n*8 +: 8] <= 8'(w_of(int'(addr_c), 256, 0, n));
    end

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] st(input int which);
        case (which)
            0:       return {busy_a, rd_a, done_a};
            1:       return {busy_b, rd_b, done_b};
            default: return {busy_c, rd_c, done_c};
        endcase
    endfunction

    task automatic start(input int which, input logic [255:0] v, input logic [1:0] m);
        vec  = v;
        mode = m;
        case (which)
            0:       load_a = 1'b1;
            1:       load_b = 1'b1;
            default: load_c = 1'b1;
        endcase
        tick;
        load_a = 1'b0;
        load_b = 1'b0;
        load_c = 1'b0;
    endtask

    task automatic wait_done(input int which, output int lat, output int busy_cnt, output int rd_cnt);
        logic [2:0] s;
        lat = -1;
        busy_cnt = 0;
        rd_cnt = 0;
        for (int k = 1; k <= 400; k++) begin
            s = st(which);
            if (s[2]) busy_cnt++;
            if (s[1]) rd_cnt++;
            tick;
            s = st(which);
            if (s[0]) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic chk_a(input string tag, input int base, input int step);
        for (int n = 0; n < NEU; n++)
            chk($sformatf("%s[%0d]", tag, n), $signed(out_a[n*32 +: 32]), 64'(base + step*n));
    endtask

    task automatic run_a(input string tag, input logic [255:0] v, input logic [1:0] m, input int exp_val);
        int lat, bc, rc;
        start(0, v, m);
        wait_done(0, lat, bc, rc);
        chk({tag, "_lat"}, lat, 35);
        chk_a(tag, exp_val, 0);
    endtask

    initial begin
        logic [255:0] ones;
        logic [255:0] v;
        int lat, bc, rc, dn;
        ones = '1;
        load_a = 1'b0; load_b = 1'b0; load_c = 1'b0;
        vec = '0; mode = 2'b00;

        repeat (3) tick;
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_done", done_a, 1'b0);
        chk("rst_sat", sat_a, 1'b0);
        chk("rst_w_rd", rd_a, 1'b0);
        chk("rst_w_addr", addr_a, 0);
        chk("rst_out", (out_a == '0), 1'b1);
        reset = 1'b0;
        tick;

        // zero input, bias ramp n-10, identity
        w_val = 3; bias_ramp = 1;
        start(0, '0, 2'b00);
        chk("t1_busy", busy_a, 1'b1);
        chk("t1_w_rd", rd_a, 1'b1);
        chk("t1_w_addr0", addr_a, 0);
        wait_done(0, lat, bc, rc);
        chk("t1_lat", lat, 35);
        chk_a("t1_out", -10, 1);
        chk("t1_sat", sat_a, 1'b0);

        // all ones, weights +1, ReLU: 256; busy 35 cycles, w_rd CHUNKS+1 cycles
        tick;
        w_val = 1; bias_ramp = 0; bias_const = 0;
        start(0, ones, 2'b01);
        wait_done(0, lat, bc, rc);
        chk("t2_lat", lat, 35);
        chk("t2_busy_cycles", bc, 35);
        chk("t2_rd_cycles", rc, 33);
        chk_a("t2_out", 256, 0);
        chk("t2_sat", sat_a, 1'b0);

        // weights -1: identity, then back-to-back ReLU loaded in the done cycle
        tick;
        w_val = -1;
        run_a("t3_ident", ones, 2'b00, -256);
        start(0, ones, 2'b01);
        chk("t3_b2b_busy", busy_a, 1'b1);
        chk("t3_hold", $signed(out_a[31:0]), -256);
        wait_done(0, lat, bc, rc);
        chk("t3_b2b_lat", lat, 35);
        chk_a("t3_relu", 0, 0);
        run_a("t3_leaky", ones, 2'b10, -32);
        bias_const = -1;
        run_a("t3_leaky_b", ones, 2'b11, -33);

        // bit ordering: only chunk 0 lane 0 weight is 7
        tick;
        special = 1; bias_const = 0; w_val = 1;
        v = '0; v[255] = 1'b1;
        run_a("t4_bit255", v, 2'b00, 7);
        v = '0; v[254] = 1'b1;
        run_a("t4_bit254", v, 2'b00, 1);
        v = '0; v[0] = 1'b1;
        run_a("t4_bit0", v, 2'b00, 1);
        special = 0;

        // load pulsed while busy is ignored
        tick;
        w_val = 2;
        start(0, ones, 2'b00);
        repeat (9) tick;
        vec = '0; load_a = 1'b1;
        tick;
        load_a = 1'b0;
        dn = 0;
        for (int k = 0; k < 80; k++) begin
            tick;
            if (done_a) dn++;
        end
        chk("t5_done_count", dn, 1);
        chk_a("t5_out", 512, 0);

        // reset mid-RUN aborts
        start(0, ones, 2'b00);
        repeat (10) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("t6_busy", busy_a, 1'b0);
        chk("t6_w_rd", rd_a, 1'b0);
        chk("t6_w_addr", addr_a, 0);
        chk("t6_out", (out_a == '0), 1'b1);
        dn = 0;
        for (int k = 0; k < 50; k++) begin
            tick;
            if (done_a) dn++;
        end
        chk("t6_no_done", dn, 0);

        // OUT_SIZE=8 saturation, then sticky flag cleared by next load
        w_val = 127; bias_const = 0;
        start(1, ones, 2'b00);
        wait_done(1, lat, bc, rc);
        chk("t7_lat", lat, 35);
        chk("t7_sat", sat_b, 1'b1);
        for (int n = 0; n < NEU; n++)
            chk($sformatf("t7_out[%0d]", n), $signed(out_b[n*8 +: 8]), 127);
        tick;
        w_val = 0;
        start(1, ones, 2'b00);
        wait_done(1, lat, bc, rc);
        chk("t7b_sat", sat_b, 1'b0);
        chk("t7b_out0", $signed(out_b[7:0]), 0);

        // LANES=1: 256 chunks
        tick;
        w_val = 1;
        start(2, ones, 2'b00);
        wait_done(2, lat, bc, rc);
        chk("t8_lat", lat, 259);
        chk("t8_busy_cycles", bc, 259);
        chk("t8_rd_cycles", rc, 257);
        chk("t8_out0", $signed(out_c[31:0]), 256);
        chk("t8_out19", $signed(out_c[19*32 +: 32]), 256);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
